reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//   Shares the register file's single write port (reg_write/write_reg/write_data) among
//   NUM_REQ requesters: datapath writeback (req 0), multi-cycle mult/div unit (req 1),
//   debug/program loader (req 2). Round-robin grant with valid/ready handshake.
//   Output is registered and drives the register file write port directly.
// PARAMETERS
//   NUM_REQ   3    number of requesters, 2..8
//   ADDR_W    5    register index width (32 registers)
//   DATA_W    32   write data width
//   CNT_W     16   width of the saturating conflict counter
// PORTS
//   clk            in   1               rising-edge clock
//   rst_n          in   1               asynchronous active-low reset
//   req_valid      in   NUM_REQ         per-requester write request
//   req_reg        in   NUM_REQ*ADDR_W  destination index; slice i = [i*ADDR_W +: ADDR_W]
//   req_data       in   NUM_REQ*DATA_W  write data; slice i = [i*DATA_W +: DATA_W]
//   req_ready      out  NUM_REQ         one-hot grant; handshake = valid & ready at posedge
//   rf_reg_write   out  1               register file write enable
//   rf_write_reg   out  ADDR_W          register file write index
//   rf_write_data  out  DATA_W          register file write data
//   conflict_cnt   out  CNT_W           cycles with more than one valid request, saturating
// BEHAVIOUR
//   - Reset (rst_n low, async): rf_reg_write=0, rf_write_reg=0, rf_write_data=0,
//     conflict_cnt=0, rr_ptr=0. req_ready forced to 0 while rst_n is low.
//   - Grant (combinational): first valid requester at or after rr_ptr, wrapping
//     NUM_REQ-1 -> 0. At most one req_ready bit set. No valid input gives req_ready=0.
//   - Requester rule: once req_valid is asserted, req_valid, req_reg and req_data are held
//     until the handshake completes. The arbiter never retracts a grant mid-cycle.
//   - rr_ptr: after a handshake by requester i, rr_ptr <= (i+1) mod NUM_REQ.
//     It is unchanged in idle cycles.
//   - Output register, updated at each posedge:
//       handshake:   rf_write_reg <= req_reg[g], rf_write_data <= req_data[g],
//                    rf_reg_write <= (req_reg[g] != 0)
//       no handshake: rf_reg_write <= 0; rf_write_reg and rf_write_data hold.
//   - Latency: handshake at edge N gives rf_reg_write high in cycle N..N+1. The register
//     file commits at edge N+1. Throughput is one write per cycle.
//   - Writes to $zero: handshake completes (ready=1) but rf_reg_write stays 0.
//   - Same destination from two requesters in one cycle: serialized in rr order.
//     The later grant overwrites (last writer wins).
//   - conflict_cnt: +1 on each posedge with popcount(req_valid) > 1 and rst_n high.
//     Saturates at 2^CNT_W-1 with no wrap.
//   - Reset mid-operation: an in-flight output write is dropped (rf_reg_write=0
//     immediately). Requests still valid after rst_n rises are re-arbitrated from rr_ptr=0.
// CONFIGURATION
//   REG_ARB_PRIO0_EN defined:
//     - requester 0 wins whenever req_valid[0]=1, regardless of rr_ptr.
//     - Other requesters use round-robin only when req 0 is idle.
//     - rr_ptr is updated only on grants to requesters 1..NUM_REQ-1.
//   REG_ARB_PRIO0_EN undefined: pure round-robin over all requesters, as above.
// STRUCTURE
//   - Package reg_arb_pkg:
//       constants REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0, DEFAULT_NUM_REQ=3;
//       typedef reg_idx_t (logic [4:0]);
//       typedef reg_word_t (logic [31:0]).
//   - Sub-module rr_arbiter (NUM_REQ): pure combinational one-hot grant from valid + ptr.
//     reg_write_arbiter owns rr_ptr, the output register and the counter.
// TESTING
//   1. Reset: rst_n=0 with all valid=1 -> req_ready=0, rf_reg_write=0, conflict_cnt=0.
//   2. Single req: req1 writes reg 8 = 0xDEADBEEF.
//      -> ready[1] same cycle; next cycle rf_reg_write=1, rf_write_reg=8,
//         rf_write_data=0xDEADBEEF.
//   3. Rotation: all 3 valid, rr_ptr=0 -> grants 0,1,2 on consecutive edges;
//      conflict_cnt=2 after 3 edges.
//   4. $zero: req0 writes reg 0 = 0x1234 -> ready[0]=1; rf_reg_write stays 0.
//   5. Same destination: req0 (0x11) and req2 (0x22) both write reg 10 -> order 0 then 2.
//      Back-to-back writes; final register file value 0x22.
//   6. Async reset during a write: rst_n falls mid-cycle while rf_reg_write=1
//      -> rf_reg_write=0 at once. Held requests restart with req0 after release;
//      with REG_ARB_PRIO0_EN, req0 is granted every cycle it is valid.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_arb_pkg;
    localparam int       REG_ADDR_W      = 5;
    localparam int       REG_DATA_W      = 32;
    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam int       DEFAULT_NUM_REQ = 3;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [REG_DATA_W-1:0] reg_word_t;
endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side write request bus: packed per-requester index/data slices plus one-hot ready.
// Latency: ready is combinational from valid.
// Backpressure: a requester holds valid/reg/data until it sees valid & ready at a posedge.
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    modport master (output req_valid, req_reg, req_data, input req_ready);
    modport slave  (input req_valid, req_reg, req_data, output req_ready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
// Latency: zero (pure combinational).
// Backpressure: none; grant is one-hot or all-zero when nothing is valid.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);
    logic [PTR_W-1:0] idx;

    // Walk from the farthest candidate back to ptr so the nearest valid one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin share of the register file write port; REG_ARB_PRIO0_EN gives req 0 strict priority.
// Latency: handshake at edge N drives rf_reg_write during cycle N..N+1; one write per cycle.
// Backpressure: ungranted requesters see ready=0 and must hold their request.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_write_arbiter_if.slave  req_bus,
    output logic                rf_reg_write,
    output logic [ADDR_W-1:0]   rf_write_reg,
    output logic [DATA_W-1:0]   rf_write_data,
    output logic [CNT_W-1:0]    conflict_cnt
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_ptr_nxt;
    logic [NUM_REQ-1:0] rr_valid;
    logic [NUM_REQ-1:0] rr_grant;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] hs;
    logic [PTR_W-1:0]   g_idx;
    logic [ADDR_W-1:0]  sel_reg;
    logic [DATA_W-1:0]  sel_data;
    logic               hs_any;
    logic               ptr_adv;
    logic               conflict;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .valid (rr_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant)
    );

`ifdef REG_ARB_PRIO0_EN
    // Req 0 bypasses the rotation; the pointer only tracks the other requesters.
    assign rr_valid = req_bus.req_valid & {{(NUM_REQ-1){1'b1}}, 1'b0};
    assign grant    = req_bus.req_valid[0] ? {{(NUM_REQ-1){1'b0}}, 1'b1} : rr_grant;
    assign ptr_adv  = hs_any && (g_idx != '0);
`else
    assign rr_valid = req_bus.req_valid;
    assign grant    = rr_grant;
    assign ptr_adv  = hs_any;
`endif

    assign req_bus.req_ready = grant & {NUM_REQ{rst_n}};
    assign hs                = req_bus.req_valid & req_bus.req_ready;
    assign hs_any            = |hs;
    assign conflict          = $countones(req_bus.req_valid) > 1;

    always_comb begin
        g_idx    = '0;
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i]) begin
                g_idx    = PTR_W'(i);
                sel_reg  = req_bus.req_reg[i*ADDR_W +: ADDR_W];
                sel_data = req_bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (ptr_adv) begin
            rr_ptr_nxt = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            rf_reg_write  <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
            conflict_cnt  <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
            if (hs_any) begin
                rf_write_reg  <= sel_reg;
                rf_write_data <= sel_data;
                // Writes to $zero still complete the handshake but never reach the file.
                rf_reg_write  <= (sel_reg != '0);
            end else begin
                rf_reg_write  <= 1'b0;
            end
            if (conflict && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus randomized traffic against a queue-free model.
module tb_reg_write_arbiter;
    import reg_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    logic            rf_reg_write;
    reg_idx_t        rf_write_reg;
    reg_word_t       rf_write_data;
    logic [CW-1:0]   conflict_cnt;

    reg_write_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .CNT_W   (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_bus       (bus),
        .rf_reg_write  (rf_reg_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .conflict_cnt  (conflict_cnt)
    );

    int        checks = 0;
    int        errors = 0;
    int        m_ptr;
    logic      m_we;
    reg_idx_t  m_reg;
    reg_word_t m_data;
    int        m_cnt;
    logic [N-1:0] last_hs;
    reg_word_t tb_rf [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec rule: first valid at or after ptr (req 0 first when it has priority), -1 if none.
    function automatic int model_grant(input logic [N-1:0] v, input int ptr);
`ifdef REG_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr + k) % N;
`ifdef REG_ARB_PRIO0_EN
            if (idx != 0 && v[idx]) return idx;
`else
            if (v[idx]) return idx;
`endif
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_ptr = 0; m_we = 1'b0; m_reg = '0; m_data = '0; m_cnt = 0; last_hs = '0;
        end else begin
            g = model_grant(bus.req_valid, m_ptr);
            if ($countones(bus.req_valid) > 1 && m_cnt < (1 << CW) - 1) m_cnt++;
            if (g >= 0) begin
                m_reg   = bus.req_reg[g*AW +: AW];
                m_data  = bus.req_data[g*DW +: DW];
                m_we    = (m_reg != REG_ZERO);
                last_hs = N'(1) << g;
`ifdef REG_ARB_PRIO0_EN
                if (g != 0) m_ptr = (g + 1) % N;
`else
                m_ptr = (g + 1) % N;
`endif
            end else begin
                m_we    = 1'b0;
                last_hs = '0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && rf_reg_write) tb_rf[rf_write_reg] <= rf_write_data;
    end

    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy;
        if (!rst_n) begin
            check("rst_ready", 64'(bus.req_ready), 64'd0);
            check("rst_we", 64'(rf_reg_write), 64'd0);
            check("rst_cnt", 64'(conflict_cnt), 64'd0);
        end else begin
            g = model_grant(bus.req_valid, m_ptr);
            exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
            check("ready", 64'(bus.req_ready), 64'(exp_rdy));
            check("rf_we", 64'(rf_reg_write), 64'(m_we));
            check("rf_reg", 64'(rf_write_reg), 64'(m_reg));
            check("rf_data", 64'(rf_write_data), 64'(m_data));
            check("cnt", 64'(conflict_cnt), 64'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input reg_idx_t r, input reg_word_t d);
        bus.req_valid[i]          = v;
        bus.req_reg[i*AW +: AW]   = r;
        bus.req_data[i*DW +: DW]  = d;
    endtask

    initial begin
        logic [N-1:0] hs_now;
        bus.req_valid = '1;
        bus.req_reg   = '0;
        bus.req_data  = '0;
        rst_n         = 1'b0;

        // Reset with every requester valid.
        repeat (3) tick();
        check("t1_ready", 64'(bus.req_ready), 64'd0);
        check("t1_we", 64'(rf_reg_write), 64'd0);
        check("t1_cnt", 64'(conflict_cnt), 64'd0);
        bus.req_valid = '0;
        tick();
        rst_n = 1'b1;

        // Single request from req 1.
        set_req(1, 1'b1, 5'd8, 32'hDEADBEEF);
        at_neg();
        check("t2_ready", 64'(bus.req_ready), 64'b010);
        tick();
        set_req(1, 1'b0, 5'd0, 32'd0);
        at_neg();
        check("t2_we", 64'(rf_reg_write), 64'd1);
        check("t2_reg", 64'(rf_write_reg), 64'd8);
        check("t2_data", 64'(rf_write_data), 64'hDEADBEEF);

        // Req 2 alone brings the pointer back to 0.
        set_req(2, 1'b1, 5'd3, 32'h33);
        tick();
        set_req(2, 1'b0, 5'd0, 32'd0);

        // Rotation with all three valid.
        set_req(0, 1'b1, 5'd1, 32'h101);
        set_req(1, 1'b1, 5'd2, 32'h102);
        set_req(2, 1'b1, 5'd3, 32'h103);
        at_neg();
        check("t3_ready0", 64'(bus.req_ready), 64'b001);
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        at_neg();
        check("t3_ready1", 64'(bus.req_ready), 64'b010);
        check("t3_data0", 64'(rf_write_data), 64'h101);
        tick();
        set_req(1, 1'b0, 5'd0, 32'd0);
        at_neg();
        check("t3_ready2", 64'(bus.req_ready), 64'b100);
        tick();
        set_req(2, 1'b0, 5'd0, 32'd0);
        at_neg();
        check("t3_cnt", 64'(conflict_cnt), 64'd2);
        check("t3_data2", 64'(rf_write_data), 64'h103);

        // Write to $zero.
        set_req(0, 1'b1, 5'd0, 32'h1234);
        at_neg();
        check("t4_ready", 64'(bus.req_ready), 64'b001);
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        at_neg();
        check("t4_we", 64'(rf_reg_write), 64'd0);
        check("t4_data", 64'(rf_write_data), 64'h1234);

        set_req(2, 1'b1, 5'd4, 32'h44);
        tick();
        set_req(2, 1'b0, 5'd0, 32'd0);

        // Same destination from req 0 and req 2.
        set_req(0, 1'b1, 5'd10, 32'h11);
        set_req(2, 1'b1, 5'd10, 32'h22);
        at_neg();
        check("t5_ready0", 64'(bus.req_ready), 64'b001);
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        at_neg();
        check("t5_we0", 64'(rf_reg_write), 64'd1);
        check("t5_data0", 64'(rf_write_data), 64'h11);
        check("t5_ready2", 64'(bus.req_ready), 64'b100);
        tick();
        set_req(2, 1'b0, 5'd0, 32'd0);
        at_neg();
        check("t5_we2", 64'(rf_reg_write), 64'd1);
        check("t5_data2", 64'(rf_write_data), 64'h22);
        tick();
        at_neg();
        check("t5_rf10", 64'(tb_rf[10]), 64'h22);

        // Async reset while a write is on the port.
        set_req(1, 1'b1, 5'd5, 32'h55);
        tick();
        set_req(1, 1'b0, 5'd0, 32'd0);
        set_req(0, 1'b1, 5'd6, 32'h66);
        set_req(2, 1'b1, 5'd7, 32'h77);
        check("t6_we_before", 64'(rf_reg_write), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_we_drop", 64'(rf_reg_write), 64'd0);
        check("t6_ready_rst", 64'(bus.req_ready), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        at_neg();
        check("t6_ready_rel", 64'(bus.req_ready), 64'b001);
        tick();
`ifdef REG_ARB_PRIO0_EN
        set_req(0, 1'b1, 5'd9, 32'h99);
        at_neg();
        check("t6_prio", 64'(bus.req_ready), 64'b001);
        tick();
`endif
        set_req(0, 1'b0, 5'd0, 32'd0);
        at_neg();
        check("t6_ready_next", 64'(bus.req_ready), 64'b100);
        tick();
        set_req(2, 1'b0, 5'd0, 32'd0);

        // Randomized traffic, narrow index range for collisions, occasional async reset.
        for (int c = 0; c < 3000; c++) begin
            tick();
            hs_now = last_hs;
            if ($urandom_range(0, 249) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] || hs_now[i]) begin
                    if ($urandom_range(0, 9) < 6)
                        set_req(i, 1'b1, 5'($urandom_range(0, 7)), 32'($urandom));
                    else
                        set_req(i, 1'b0, 5'd0, 32'd0);
                end
            end
        end
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
